// File: rtl/mitchell_lut_if.sv
// mitchell_lut_if
//   Bundles the operand mantissas and the correction term that pass between
//   the Mitchell multiplier datapath and its error-correction lookup table.
//
//   Signals:
//     a  [6:0]  fractional mantissa of operand A (xa = a/128)
//     b  [6:0]  fractional mantissa of operand B (xb = b/128)
//     c  [9:0]  registered correction term (E * 2^11)
//
//   Modports:
//     master  drives a/b and reads c (multiplier datapath side)
//     slave   reads a/b and drives c (lookup table side)
interface mitchell_lut_if;
  logic [6:0] a;
  logic [6:0] b;
  logic [9:0] c;

  modport master (output a, output b, input c);
  modport slave  (input a, input b, output c);
endinterface

// File: rtl/mitchell_lut.sv
// mitchell_lut
//   Error-correction lookup table for a Mitchell logarithmic multiplier.
//   The top three bits of each fractional mantissa select one cell of an 8x8
//   grid. Each cell holds the exact Mitchell error at its lower corner,
//   scaled by 2^11. The result is registered, so there is one cycle of
//   latency and no stall.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; clears c to 0
//     bus    mitchell_lut_if slave modport (a, b in; c out)
module mitchell_lut (
  input  logic              clk,
  input  logic              rst_n,
  mitchell_lut_if.slave     bus
);

  logic [2:0] ia;
  logic [2:0] ib;
  logic [9:0] table_val;

  // The low four mantissa bits fall inside a grid cell and do not affect
  // the correction.
  assign ia = bus.a[6:4];
  assign ib = bus.b[6:4];

  // Case ROM indexed by {ia, ib}.
  // Without a mantissa carry (ia + ib < 8) the error is ia*ib/64.
  // With a carry (ia + ib >= 8) it is (8-ia)*(8-ib)/64.
  // Each entry stores 32 * P. The largest value is 512 (ia = ib = 4), so
  // the output fits in 10 bits with the low five bits always zero.
  always_comb begin
    table_val = 10'd0;
    case ({ia, ib})
      6'o00: table_val = 10'd0;
      6'o01: table_val = 10'd0;
      6'o02: table_val = 10'd0;
      6'o03: table_val = 10'd0;
      6'o04: table_val = 10'd0;
      6'o05: table_val = 10'd0;
      6'o06: table_val = 10'd0;
      6'o07: table_val = 10'd0;

      6'o10: table_val = 10'd0;
      6'o11: table_val = 10'd32;
      6'o12: table_val = 10'd64;
      6'o13: table_val = 10'd96;
      6'o14: table_val = 10'd128;
      6'o15: table_val = 10'd160;
      6'o16: table_val = 10'd192;
      6'o17: table_val = 10'd224;

      6'o20: table_val = 10'd0;
      6'o21: table_val = 10'd64;
      6'o22: table_val = 10'd128;
      6'o23: table_val = 10'd192;
      6'o24: table_val = 10'd256;
      6'o25: table_val = 10'd320;
      6'o26: table_val = 10'd384;
      6'o27: table_val = 10'd192;

      6'o30: table_val = 10'd0;
      6'o31: table_val = 10'd96;
      6'o32: table_val = 10'd192;
      6'o33: table_val = 10'd288;
      6'o34: table_val = 10'd384;
      6'o35: table_val = 10'd480;
      6'o36: table_val = 10'd320;
      6'o37: table_val = 10'd160;

      6'o40: table_val = 10'd0;
      6'o41: table_val = 10'd128;
      6'o42: table_val = 10'd256;
      6'o43: table_val = 10'd384;
      6'o44: table_val = 10'd512;
      6'o45: table_val = 10'd384;
      6'o46: table_val = 10'd256;
      6'o47: table_val = 10'd128;

      6'o50: table_val = 10'd0;
      6'o51: table_val = 10'd160;
      6'o52: table_val = 10'd320;
      6'o53: table_val = 10'd480;
      6'o54: table_val = 10'd384;
      6'o55: table_val = 10'd288;
      6'o56: table_val = 10'd192;
      6'o57: table_val = 10'd96;

      6'o60: table_val = 10'd0;
      6'o61: table_val = 10'd192;
      6'o62: table_val = 10'd384;
      6'o63: table_val = 10'd320;
      6'o64: table_val = 10'd256;
      6'o65: table_val = 10'd192;
      6'o66: table_val = 10'd128;
      6'o67: table_val = 10'd64;

      6'o70: table_val = 10'd0;
      6'o71: table_val = 10'd224;
      6'o72: table_val = 10'd192;
      6'o73: table_val = 10'd160;
      6'o74: table_val = 10'd128;
      6'o75: table_val = 10'd96;
      6'o76: table_val = 10'd64;
      6'o77: table_val = 10'd32;

      default: table_val = 10'd0;
    endcase
  end

  // The output register is the only state. Reset discards any pending value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.c <= 10'd0;
    end else begin
      bus.c <= table_val;
    end
  end

endmodule

// File: tb/tb_mitchell_lut.sv
// tb_mitchell_lut
//   Self-checking bench for mitchell_lut. It compares the registered
//   correction term against a reference built from the Mitchell error
//   formula on the 8x8 grid. Stimulus covers reset, the full grid,
//   low-bit independence, the carry boundary, symmetry and latency,
//   asynchronous reset, and random operands.
module tb_mitchell_lut;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mitchell_lut_if bus ();

  mitchell_lut dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact Mitchell error at the lower corner of the cell, times 2^11.
  function automatic int refC(input int av, input int bv);
    int xa;
    int xb;
    int p;
    xa = av / 16;
    xb = bv / 16;
    if (xa + xb < 8) p = xa * xb;
    else             p = (8 - xa) * (8 - xb);
    return 32 * p;
  endfunction

  // Drive new operands away from the active edge.
  task automatic applyStimulus(input int av, input int bv);
    @(negedge clk);
    bus.a = av[6:0];
    bus.b = bv[6:0];
  endtask

  task automatic checkOutput(input string tag, input int expected);
    checks++;
    assert (int'(bus.c) === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, bus.c, expected);
    end
  endtask

  // Apply operands, wait for the capturing edge, then check just after it.
  task automatic stepAndCheck(input string tag, input int av, input int bv, input int expected);
    applyStimulus(av, bv);
    @(posedge clk);
    #1;
    checkOutput(tag, expected);
  endtask

  initial begin
    int ra;
    int rb;
    checks   = 0;
    failures = 0;

    // Reset held with a = b = 64: c must stay 0 across edges.
    rst_n = 1'b0;
    bus.a = 7'd64;
    bus.b = 7'd64;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release", 512);

    // Full grid sweep, checked against the formula.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        stepAndCheck($sformatf("grid_%0d_%0d", i, j), 16 * i, 16 * j, refC(16 * i, 16 * j));
      end
    end

    // Spot checks with constant expectations.
    stepAndCheck("spot_0_0",     0,   0,   0);
    stepAndCheck("spot_32_48",   32,  48,  192);
    stepAndCheck("spot_48_64",   48,  64,  384);
    stepAndCheck("spot_64_64",   64,  64,  512);
    stepAndCheck("spot_112_16",  112, 16,  224);
    stepAndCheck("spot_112_112", 112, 112, 32);
    stepAndCheck("spot_80_48",   80,  48,  480);

    // Low mantissa bits must not matter.
    stepAndCheck("lowbits_base", 48, 64, 384);
    stepAndCheck("lowbits_set",  63, 79, 384);

    // Symmetry and one-cycle latency: before each edge c still shows the
    // previous result.
    applyStimulus(16, 96);
    #1;
    checkOutput("latency_before_1", 384);
    @(posedge clk);
    #1;
    checkOutput("sym_16_96", 192);
    applyStimulus(0, 0);
    @(posedge clk);
    #1;
    checkOutput("latency_zero", 0);
    applyStimulus(96, 16);
    #1;
    checkOutput("latency_before_2", 0);
    @(posedge clk);
    #1;
    checkOutput("sym_96_16", 192);

    // Asynchronous reset mid-cycle while c = 384.
    stepAndCheck("async_pre", 48, 64, 384);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 0);
    @(posedge clk);
    #1;
    checkOutput("async_hold", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("async_release", 384);

    // Random operands including arbitrary low bits, plus symmetry.
    for (int k = 0; k < 40; k++) begin
      ra = int'($urandom_range(0, 127));
      rb = int'($urandom_range(0, 127));
      stepAndCheck($sformatf("rand_%0d_a%0d_b%0d", k, ra, rb), ra, rb, refC(ra, rb));
      stepAndCheck($sformatf("rand_sym_%0d", k), rb, ra, refC(ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mitchell_lut.md
# mitchell_lut

Error-correction lookup table for a Mitchell logarithmic multiplier. It takes the fractional mantissas of the two operand logarithms and returns the Mitchell approximation error term, quantised on an 8x8 grid. The multiplier datapath adds this term back to the antilog stage. Output is registered, giving one cycle of latency.

## Interface
Parameters: none; all widths are fixed.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  7  fractional mantissa of operand A; unsigned, xa = a/128.
- b  input  7  fractional mantissa of operand B; unsigned, xb = b/128.
- c  output  10  correction term; unsigned, value = E * 2^11, where E is the error in units of the product's leading power of two.

## Operation
- Index selection:
  - ia = a[6:4], ib = b[6:4], each 0..7.
  - a[3:0] and b[3:0] are ignored.
- Table content: 64 entries. Each entry is the exact Mitchell error at the cell's lower corner (xa = ia/8, xb = ib/8).
  - If ia + ib < 8 (no mantissa carry): P = ia * ib.
  - If ia + ib >= 8 (carry case): P = (8 - ia) * (8 - ib).
  - c = 32 * P.
- Range and widths:
  - P max is 16 (at ia = ib = 4), so c max is 512 and always fits in 10 bits with no saturation.
  - c[4:0] is always 0.
- Symmetry: c(a, b) == c(b, a) for all inputs.
- The table is combinational (case ROM, or equivalent arithmetic that produces the same 64 values), followed by the output register.
- There are no undefined or X outputs for any input value.

## Timing
- The c register updates on every rising clk edge, capturing the table value for the a and b present at that edge.
- Latency is 1 cycle from inputs to c. There is no enable, no handshake, and no stall.
- Reset:
  - rst_n low clears c to 0 immediately, independent of clk.
  - While rst_n is low, c holds 0.
  - On the first rising edge after rst_n deasserts, c loads the table value.
- Reset asserted mid-stream discards the pending value. There is no other state.
- Boundaries:
  - ia + ib == 8 is in the carry case.
  - ia = 0 or ib = 0 gives c = 0.
  - ia = ib = 7 gives c = 32.

## Test plan
- Reset: hold rst_n = 0 with a = 64, b = 64 and toggle clk. c must stay 0. Release reset; one edge later c must be 512.
- Full grid sweep: a = 16*i, b = 16*j for i, j in 0..7, one value per cycle. Compare c against the formula. Spot checks:
  - (0, 0) gives 0.
  - (32, 48) gives 192.
  - (48, 64) gives 384.
  - (64, 64) gives 512.
  - (112, 16) gives 224.
  - (112, 112) gives 32.
- Low-bit independence: a = 48, b = 64 gives 384. Then a = 63, b = 79 must also give 384.
- Carry boundary:
  - a = 48, b = 64 (sum 7) gives 384.
  - a = 64, b = 64 (sum 8) gives 512.
  - a = 80, b = 48 (sum 8) gives 480.
- Symmetry and latency: apply (16, 96) then (96, 16) on consecutive cycles. c must read 192 on both following cycles, each exactly one cycle after its input.
- Async reset mid-stream: assert rst_n low between clock edges while c = 384. c must go to 0 without a clock edge.
